spu_fetch_buffer: RTL and testbench
===================================

// Module: spu_fetch_buffer
// PURPOSE
//  Instruction fetch stage directly upstream of the local store (LS). It drives quadword read
//  addresses into the LS port, buffers the returned 128-bit quadwords, and delivers aligned
//  instruction pairs (2 x 32-bit) to decode with a valid/ready handshake. It also handles
//  branch redirects, stop/halt and PC wrap-around. LS read data is combinational, in the same
//  cycle as the address.
// PARAMETERS
//  LS_QW      LS_SIZE/16  LS depth in quadwords; the fetch address wraps modulo LS_QW (power of 2)
//  BUF_DEPTH  2           quadword buffer entries (>=2)
//  PC_RESET   0           byte address of the first fetch after reset (16-byte aligned)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous active-high reset
//  ls_rd_req   out  1      fetch requests the LS port this cycle
//  ls_gnt      in   1      LS port granted to fetch this cycle (load/store has priority)
//  ls_addr     out  32     quadword index of the fetch (0..LS_QW-1)
//  ls_data_rd  in   128    LS read quadword; valid in the same cycle as ls_gnt
//  pair_valid  out  1      instr_pair valid
//  pair_ready  in   1      decode accepts the pair
//  instr_pair  out  64     [0:31] slot0 (even word), [32:63] slot1 (odd word)
//  pair_mask   out  2      per-slot valid; 2'b01 = slot0 invalid (odd branch target)
//  pair_pc     out  32     8-byte-aligned byte address of the pair
//  br_taken    in   1      redirect strobe from branch resolution
//  br_target   in   32     redirect byte address (word-aligned; bits [30:31] ignored)
//  stop_req    in   1      stop instruction retired; halt fetch
//  halted      out  1      fetch is in HALT
// BEHAVIOUR
//  - Reset: state=IDLE, buffer empty, fetch_qw=PC_RESET>>4, pair_sel=0, first_mask=2'b11.
//    All outputs are 0, except ls_addr=PC_RESET>>4. Reset mid-operation discards any granted
//    data and buffer contents.
//  - FSM: IDLE -> RUN after one cycle. RUN -> HALT on stop_req. HALT -> RUN on br_taken, which
//    also redirects. br_taken beats stop_req when both arrive in the same cycle.
//  - Fetch (RUN only): ls_rd_req=1 when count<BUF_DEPTH, or when count==BUF_DEPTH and the head
//    pops this cycle. ls_addr=fetch_qw. When ls_rd_req&&ls_gnt, on the edge:
//    tail<={ls_data_rd,fetch_qw}; fetch_qw<=(fetch_qw+1)%LS_QW.
//  - A push and a pop in the same cycle leave count unchanged.
//  - Output: pair_valid=(state==RUN)&&(count>0)&&!br_taken.
//  - instr_pair = head quadword words {2*pair_sel, 2*pair_sel+1}.
//  - pair_pc = {head_qw,4'b0} + (pair_sel<<3). pair_mask = first_mask for the first pair
//    after a redirect, else 2'b11.
//  - Handshake: on pair_valid&&pair_ready, pair_sel toggles. When pair_sel was 1, the head
//    entry pops. The first accepted pair sets first_mask<=2'b11.
//  - Redirect: br_taken (any state except during rst) takes priority over everything that
//    cycle. ls_rd_req=0 and pair_valid=0 that cycle; grant and handshake are ignored. On the edge:
//    - buffer flushed (count=0)
//    - fetch_qw<=br_target[0:27]%LS_QW
//    - pair_sel<=br_target[28]
//    - first_mask<=br_target[29] ? 2'b01 : 2'b11
//    - state<=RUN
//  - Redirect latency: the first target pair is valid 1 cycle after the grant of the
//    target quadword.
//  - Start/head offset: the first quadword after a redirect begins at pair_sel (0 or 1). Later
//    quadwords begin at pair 0.
//  - HALT: no requests, pair_valid=0, halted=1, buffer contents kept but not presented.
//  - Steady state with ls_gnt=1 and pair_ready=1: one pair per cycle and no bubbles
//    (2 pairs per quadword, so 1 fetch per 2 cycles suffices).
//  - Wrap: fetch_qw==LS_QW-1 advances to 0. pair_pc wraps accordingly.
// TESTING
//  1. Reset, PC_RESET=0, LS words = index, gnt=1, ready=1
//     -> pairs {0,1},{2,3},{4,5} on consecutive cycles, pc 0,8,16.
//  2. ready=0 for 10 cycles
//     -> count saturates at BUF_DEPTH, ls_rd_req=0. Release -> pairs resume in order, none
//        lost or duplicated.
//  3. gnt held 0 for 5 cycles mid-stream
//     -> pair_valid drops after the buffer drains, ls_addr holds; resumes on gnt.
//  4. br_taken, target 0x0000_0134 (qw 0x13, word 1)
//     -> flush; first pair pc 0x130, mask 2'b01, words {4C,4D}; next pc 0x138, mask 2'b11.
//  5. stop_req while full
//     -> halted=1, no requests/pairs; later br_taken to 0x40 -> first pair pc 0x40.
//  6. Redirect to (LS_QW-1)*16+8
//     -> pair pc (LS_QW-1)*16+8, then pc 0 next (wrap). Assert rst mid-stream -> all
//        outputs 0 the next cycle.

Source files
------------

// File: rtl/spu_fetch_buffer_if.sv
// Fetch-side bus bundle: the LS read port plus the decode pair handshake.
// master = fetch buffer, slave = LS arbiter / decode.
interface spu_fetch_buffer_if;
  logic         ls_rd_req;
  logic         ls_gnt;
  logic [31:0]  ls_addr;
  logic [127:0] ls_data_rd;
  logic         pair_valid;
  logic         pair_ready;
  logic [63:0]  instr_pair;
  logic [1:0]   pair_mask;
  logic [31:0]  pair_pc;

  modport master (
    output ls_rd_req, ls_addr, pair_valid, instr_pair, pair_mask, pair_pc,
    input  ls_gnt, ls_data_rd, pair_ready
  );

  modport slave (
    input  ls_rd_req, ls_addr, pair_valid, instr_pair, pair_mask, pair_pc,
    output ls_gnt, ls_data_rd, pair_ready
  );
endinterface

// File: rtl/spu_fetch_buffer.sv
// Instruction fetch buffer: fetches quadwords from the local store, queues them and
// hands instruction pairs to decode. Handles redirects, stop/halt and LS wrap.
// Quadwords are big-endian: word 0 sits in [127:96], word 3 in [31:0]; slot0 of
// instr_pair is [63:32]. pair_mask[1] is slot0, pair_mask[0] is slot1.
module spu_fetch_buffer #(
  parameter int unsigned LS_QW     = 16384,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] PC_RESET  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  spu_fetch_buffer_if.master    bus,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  stop_req,
  output logic                  halted
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] QMASK = 32'(LS_QW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t         state, state_nxt;
  logic [127:0]   buf_data [BUF_DEPTH];
  logic [27:0]    buf_qw   [BUF_DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic [31:0]    fetch_qw;
  logic           pair_sel;
  logic [1:0]     first_mask;

  logic           run, pair_valid_i, accept, pop, rd_req, push;
  logic [127:0]   head_data;
  logic [63:0]    head_pair;
  logic [31:0]    head_pc;
  logic           unused_tgt_bits;

  assign unused_tgt_bits = ^br_target[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run          = (state == S_RUN);
  assign pair_valid_i = run && (count != '0) && !br_taken;
  assign accept       = pair_valid_i && bus.pair_ready;
  assign pop          = accept && pair_sel;
  // A full buffer may still fetch when its head retires this cycle.
  assign rd_req       = run && !br_taken && ((count < CW'(BUF_DEPTH)) || pop);
  assign push         = rd_req && bus.ls_gnt;

  assign head_data = buf_data[head];
  assign head_pair = pair_sel ? head_data[63:0] : head_data[127:64];
  assign head_pc   = {buf_qw[head], 4'b0} + {28'b0, pair_sel, 3'b0};

  assign bus.ls_rd_req  = rd_req;
  assign bus.ls_addr    = fetch_qw;
  assign bus.pair_valid = pair_valid_i;
  assign bus.instr_pair = pair_valid_i ? head_pair  : '0;
  assign bus.pair_pc    = pair_valid_i ? head_pc    : '0;
  assign bus.pair_mask  = pair_valid_i ? first_mask : '0;
  assign halted         = (state == S_HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a redirect always lands in RUN and overrides a simultaneous stop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_RUN;
      S_RUN:   if (stop_req) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (br_taken) state_nxt = S_RUN;
  end

  // Buffer pointers, fetch address and pair cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_qw   <= PC_RESET >> 4;
      pair_sel   <= 1'b0;
      first_mask <= 2'b11;
    end else if (br_taken) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_qw   <= {4'b0, br_target[31:4]} & QMASK;
      pair_sel   <= br_target[3];
      first_mask <= br_target[2] ? 2'b01 : 2'b11;
    end else begin
      if (push) begin
        tail     <= ptr_inc(tail);
        fetch_qw <= (fetch_qw + 32'd1) & QMASK;
      end
      if (accept) begin
        pair_sel   <= ~pair_sel;
        first_mask <= 2'b11;
      end
      if (pop) head <= ptr_inc(head);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Quadword storage; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= bus.ls_data_rd;
      buf_qw[tail]   <= fetch_qw[27:0];
    end
  end

endmodule

// File: tb/tb_spu_fetch_buffer.sv
// Testbench for spu_fetch_buffer: reset/streaming table, directed corner sequences,
// then randomized traffic against a program-order reference model.
module tb_spu_fetch_buffer;
  localparam int unsigned LS_QW    = 64;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] PC_RST   = 32'h0;
  localparam logic [31:0] LS_BYTES = 32'(LS_QW * 16);

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stop_req;
  logic        halted;

  spu_fetch_buffer_if bus();

  spu_fetch_buffer #(.LS_QW(LS_QW), .BUF_DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
    .clk(clk), .rst(rst), .bus(bus), .br_taken(br_taken),
    .br_target(br_target), .stop_req(stop_req), .halted(halted)
  );

  always #5 clk = ~clk;

  // LS contents: every 32-bit word holds its own word index, big-endian in the quadword.
  function automatic logic [127:0] qw_data(input logic [31:0] a);
    logic [31:0] b;
    b = a << 2;
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction
  assign bus.ls_data_rd = qw_data(bus.ls_addr);

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the pair stream is program order from the last redirect,
  // the LS request stream is consecutive quadwords from the last redirect.
  logic [31:0] exp_pc, exp_fetch;
  logic [1:0]  exp_mask;
  logic        m_halted, m_idle, run_now, prev_run_gnt;
  int unsigned pairs_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = PC_RST; exp_fetch = PC_RST >> 4; exp_mask = 2'b11;
      m_halted = 1'b0; m_idle = 1'b1; prev_run_gnt = 1'b0;
    end else begin
      run_now = !m_halted && !m_idle && !br_taken;
      chk("halted", halted, m_halted);
      if (!run_now) begin
        chk("valid_blocked", bus.pair_valid, 1'b0);
        chk("req_blocked", bus.ls_rd_req, 1'b0);
      end
      if (run_now && prev_run_gnt) chk("no_bubble", bus.pair_valid, 1'b1);
      if (bus.pair_valid) begin
        chk("model_pc", bus.pair_pc, exp_pc);
        chk("model_mask", bus.pair_mask, exp_mask);
        chk("model_instr", bus.instr_pair, {exp_pc >> 2, (exp_pc >> 2) + 32'd1});
        if (bus.pair_ready) begin
          exp_pc = (exp_pc + 32'd8) % LS_BYTES;
          exp_mask = 2'b11;
          pairs_seen++;
        end
      end
      if (bus.ls_rd_req && bus.ls_gnt) begin
        chk("fetch_addr", bus.ls_addr, exp_fetch);
        exp_fetch = (exp_fetch + 32'd1) % LS_QW;
      end
      prev_run_gnt = run_now && bus.ls_gnt;
      if (br_taken) begin
        exp_pc = (br_target & ~32'd7) % LS_BYTES;
        exp_mask = br_target[2] ? 2'b01 : 2'b11;
        exp_fetch = (br_target >> 4) % LS_QW;
        m_halted = 1'b0; m_idle = 1'b0;
      end else if (m_idle) m_idle = 1'b0;
      else if (stop_req && !m_halted) m_halted = 1'b1;
    end
  end

  typedef struct {
    logic gnt, ready, exp_req;
    logic [31:0] exp_addr;
    logic exp_valid;
    logic [31:0] exp_pc, w0, w1;
  } vec_t;
  vec_t tbl [7];

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic wait_pair(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.pair_valid) ok = 1'b1;
      else adv();
    end
    chk(nm, ok, 1'b1);
  endtask

  logic [31:0] a0;

  initial begin
    // Streaming from reset with grant and ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  32'd0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0,  32'd0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b1, 32'd0,  32'd0, 32'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b1, 32'd8,  32'd2, 32'd3};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 32'd16, 32'd4, 32'd5};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 32'd24, 32'd6, 32'd7};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'd4, 1'b1, 32'd32, 32'd8, 32'd9};

    rst = 1'b1; bus.ls_gnt = 1'b0; bus.pair_ready = 1'b0;
    br_taken = 1'b0; br_target = '0; stop_req = 1'b0;
    adv(); adv();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.ls_gnt = tbl[i].gnt; bus.pair_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), bus.ls_rd_req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), bus.ls_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), bus.pair_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), bus.pair_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), bus.instr_pair, {tbl[i].w0, tbl[i].w1});
        chk($sformatf("tbl%0d_mask", i), bus.pair_mask, 2'b11);
      end
      adv();
    end

    // Decode stalls: buffer fills, fetching stops, pairs stay presented.
    bus.pair_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("stall_req", bus.ls_rd_req, 1'b0);
        chk("stall_valid", bus.pair_valid, 1'b1);
      end
      adv();
    end
    bus.pair_ready = 1'b1;
    repeat (6) adv();

    // Grant withheld: buffer drains, address holds, then resumes.
    bus.ls_gnt = 1'b0;
    @(negedge clk); a0 = bus.ls_addr; adv();
    repeat (4) adv();
    @(negedge clk);
    chk("nognt_valid", bus.pair_valid, 1'b0);
    chk("nognt_addr", bus.ls_addr, a0);
    adv();
    bus.ls_gnt = 1'b1;
    repeat (3) adv();
    @(negedge clk);
    chk("regnt_valid", bus.pair_valid, 1'b1);
    adv();

    // Redirect to an odd word: first pair has slot0 masked.
    br_taken = 1'b1; br_target = 32'h0000_0134;
    @(negedge clk);
    chk("br_valid", bus.pair_valid, 1'b0);
    chk("br_req", bus.ls_rd_req, 1'b0);
    adv();
    br_taken = 1'b0;
    @(negedge clk);
    chk("br_fetch_req", bus.ls_rd_req, 1'b1);
    chk("br_fetch_addr", bus.ls_addr, 32'h13);
    chk("br_gap_valid", bus.pair_valid, 1'b0);
    adv();
    @(negedge clk);
    chk("br_first_valid", bus.pair_valid, 1'b1);
    chk("br_first_pc", bus.pair_pc, 32'h130);
    chk("br_first_mask", bus.pair_mask, 2'b01);
    chk("br_first_instr", bus.instr_pair, {32'h4C, 32'h4D});
    adv();
    @(negedge clk);
    chk("br_next_pc", bus.pair_pc, 32'h138);
    chk("br_next_mask", bus.pair_mask, 2'b11);
    chk("br_next_instr", bus.instr_pair, {32'h4E, 32'h4F});
    adv();

    // Stop while full, then restart with a redirect.
    bus.pair_ready = 1'b0;
    repeat (4) adv();
    stop_req = 1'b1;
    @(negedge clk);
    chk("stop_cycle_halted", halted, 1'b0);
    adv();
    stop_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_req", bus.ls_rd_req, 1'b0);
      chk("halt_valid", bus.pair_valid, 1'b0);
      adv();
    end
    br_taken = 1'b1; br_target = 32'h40; bus.pair_ready = 1'b1;
    adv();
    br_taken = 1'b0;
    wait_pair("halt_restart_timeout");
    chk("halt_restart_pc", bus.pair_pc, 32'h40);
    adv();

    // Redirect into the last quadword's second pair, then wrap to 0.
    br_taken = 1'b1; br_target = (LS_QW - 1) * 16 + 8;
    adv();
    br_taken = 1'b0;
    wait_pair("wrap_timeout");
    chk("wrap_pc_last", bus.pair_pc, (LS_QW - 1) * 16 + 8);
    chk("wrap_instr_last", bus.instr_pair, {32'((LS_QW - 1) * 4 + 2), 32'((LS_QW - 1) * 4 + 3)});
    adv();
    @(negedge clk);
    chk("wrap_pc_zero", bus.pair_pc, 32'h0);
    chk("wrap_instr_zero", bus.instr_pair, {32'd0, 32'd1});
    adv();
    repeat (2) adv();

    // Reset mid-stream.
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", bus.ls_rd_req, 1'b0);
    chk("rst_valid", bus.pair_valid, 1'b0);
    chk("rst_instr", bus.instr_pair, 64'h0);
    chk("rst_mask", bus.pair_mask, 2'b00);
    chk("rst_pc", bus.pair_pc, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_addr", bus.ls_addr, PC_RST >> 4);
    adv();

    // Randomized traffic checked by the reference model.
    for (int i = 0; i < 2000; i++) begin
      bus.ls_gnt     = ($urandom % 4) != 0;
      bus.pair_ready = ($urandom % 10) < 7;
      br_taken       = ($urandom % 25) == 0;
      br_target      = $urandom & 32'hFFFF_FFFC;
      stop_req       = ($urandom % 30) == 0;
      adv();
    end
    br_taken = 1'b0; stop_req = 1'b0;
    @(negedge clk);
    chk("random_progress", pairs_seen > 300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
